// File: rtl/lag_meas_if.sv
// Bundle of the sequencer's control, sensor, pattern and result signals.
// Strobe semantics (the only handshake form on this bus): start, sample_valid
// and pattern_ack are single-cycle qualifiers, sampled on the rising clock edge
// with no back-pressure. The sequencer accepts a strobe only in a state that
// consumes it and silently drops it elsewhere. abort is a level. result_valid
// is a level that holds baseline/lag_cycles/timeout stable until the next
// accepted start or an abort.
interface lag_meas_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             abort;
    logic [7:0]       delta;
    logic [7:0]       sample;
    logic             sample_valid;
    logic             pattern_ack;
    logic             als_run_en;
    logic             pattern_white;
    logic             busy;
    logic             result_valid;
    logic             timeout;
    logic [7:0]       baseline;
    logic [CNT_W-1:0] lag_cycles;

    // Environment side: drives requests and sensor/generator strobes.
    modport master (
        output start, abort, delta, sample, sample_valid, pattern_ack,
        input  als_run_en, pattern_white, busy, result_valid, timeout,
               baseline, lag_cycles
    );

    // Sequencer side.
    modport slave (
        input  start, abort, delta, sample, sample_valid, pattern_ack,
        output als_run_en, pattern_white, busy, result_valid, timeout,
               baseline, lag_cycles
    );
endinterface

// File: rtl/lag_meas_ctrl.sv
// Input-lag shot sequencer: warms up the ALS reader, averages a black
// baseline over 8 samples, requests white and counts cycles from the
// generator's frame-start acknowledge to the first sample above
// baseline + delta. A watchdog ends the shot if nothing arrives.
module lag_meas_ctrl #(
    parameter int SETTLE_SAMPLES = 16,
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int CNT_W          = 32
) (
    input  logic        clk,
    input  logic        resetn,
    lag_meas_if.slave   bus,
    output logic [2:0]  o_dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_BASE    = 3'd2,
        S_ARM     = 3'd3,
        S_MEASURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [7:0]       LP_SETTLE_LAST = 8'(SETTLE_SAMPLES - 1);
    localparam logic [CNT_W-1:0] LP_WD_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_WD_LIMIT    = CNT_W'(TIMEOUT_CYCLES);

    state_t           r_state;
    logic [7:0]       r_settle_cnt;
    logic [2:0]       r_base_cnt;
    logic [10:0]      r_sum;
    logic [7:0]       r_delta;
    logic [CNT_W-1:0] r_cnt;       // watchdog and lag counter share one register
    logic             r_als_run_en;
    logic             r_pattern_white;
    logic             r_busy;
    logic             r_result_valid;
    logic             r_timeout;
    logic [7:0]       r_baseline;
    logic [CNT_W-1:0] r_lag_cycles;

    logic [10:0]      w_sum_next;
    logic [8:0]       w_thresh;
    logic             w_qual;
    logic             w_wd_expired;

    // Threshold is 9 bits so baseline + delta above 255 simply never matches.
    assign w_sum_next   = r_sum + {3'b000, bus.sample};
    assign w_thresh     = {1'b0, r_baseline} + {1'b0, r_delta};
    assign w_qual       = bus.sample_valid && ({1'b0, bus.sample} >= w_thresh);
    assign w_wd_expired = (r_cnt == LP_WD_LAST);

    // Sequencer state, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn || bus.abort) begin
            r_state         <= S_IDLE;
            r_settle_cnt    <= '0;
            r_base_cnt      <= '0;
            r_sum           <= '0;
            r_delta         <= '0;
            r_cnt           <= '0;
            r_als_run_en    <= 1'b0;
            r_pattern_white <= 1'b0;
            r_busy          <= 1'b0;
            r_result_valid  <= 1'b0;
            r_timeout       <= 1'b0;
            r_baseline      <= '0;
            r_lag_cycles    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state        <= S_SETTLE;
                        r_delta        <= bus.delta;
                        r_settle_cnt   <= '0;
                        r_als_run_en   <= 1'b1;
                        r_busy         <= 1'b1;
                        r_result_valid <= 1'b0;
                        r_timeout      <= 1'b0;
                        r_lag_cycles   <= '0;
                    end
                end
                S_SETTLE: begin
                    if (bus.sample_valid) begin
                        if (r_settle_cnt == LP_SETTLE_LAST) begin
                            r_state    <= S_BASE;
                            r_base_cnt <= '0;
                            r_sum      <= '0;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 8'd1;
                        end
                    end
                end
                S_BASE: begin
                    if (bus.sample_valid) begin
                        r_sum      <= w_sum_next;
                        r_base_cnt <= r_base_cnt + 3'd1;
                        if (r_base_cnt == 3'd7) begin
                            r_baseline      <= w_sum_next[10:3];
                            r_pattern_white <= 1'b1;
                            r_cnt           <= '0;
                            r_state         <= S_ARM;
                        end
                    end
                end
                S_ARM: begin
                    if (bus.pattern_ack) begin
                        r_cnt   <= '0;
                        r_state <= S_MEASURE;
                    end else if (w_wd_expired) begin
                        r_state         <= S_DONE;
                        r_timeout       <= 1'b1;
                        r_lag_cycles    <= LP_WD_LIMIT;
                        r_result_valid  <= 1'b1;
                        r_busy          <= 1'b0;
                        r_als_run_en    <= 1'b0;
                        r_pattern_white <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (w_qual || w_wd_expired) begin
                        r_state         <= S_DONE;
                        r_timeout       <= !w_qual;
                        r_lag_cycles    <= w_qual ? (r_cnt + CNT_W'(1)) : LP_WD_LIMIT;
                        r_result_valid  <= 1'b1;
                        r_busy          <= 1'b0;
                        r_als_run_en    <= 1'b0;
                        r_pattern_white <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.als_run_en    = r_als_run_en;
    assign bus.pattern_white = r_pattern_white;
    assign bus.busy          = r_busy;
    assign bus.result_valid  = r_result_valid;
    assign bus.timeout       = r_timeout;
    assign bus.baseline      = r_baseline;
    assign bus.lag_cycles    = r_lag_cycles;
    assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_lag_meas_ctrl.sv
// Directed bench for lag_meas_ctrl with a short settle count and watchdog.
module tb_lag_meas_ctrl;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 1000;
    localparam int CW      = 32;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_BASE    = 3'd2;
    localparam logic [2:0] ST_ARM     = 3'd3;
    localparam logic [2:0] ST_MEASURE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    logic       clk;
    logic       resetn;
    logic [2:0] dbg_state;
    int         checks;
    int         errors;

    lag_meas_if #(.CNT_W(CW)) bus ();

    lag_meas_ctrl #(
        .SETTLE_SAMPLES (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge; outputs are read 1 ns later, strobes dropped after use.
    task automatic cycle();
        @(posedge clk);
        #1;
        bus.start        = 1'b0;
        bus.sample_valid = 1'b0;
        bus.pattern_ack  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic send_sample(input logic [7:0] v);
        bus.sample       = v;
        bus.sample_valid = 1'b1;
        cycle();
    endtask

    task automatic do_start(input logic [7:0] d);
        bus.delta = d;
        bus.start = 1'b1;
        cycle();
    endtask

    // Start a shot, pass settle, and feed baseline b0 followed by 7 x bx.
    task automatic run_to_arm(input logic [7:0] d, input logic [7:0] b0, input logic [7:0] bx);
        do_start(d);
        send_sample(8'd200);
        send_sample(8'd3);
        send_sample(b0);
        repeat (7) send_sample(bx);
    endtask

    task automatic ack();
        bus.pattern_ack = 1'b1;
        cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.delta = '0;
        bus.sample = '0; bus.sample_valid = 1'b0; bus.pattern_ack = 1'b0;
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;

        // reset state
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_als", 32'(bus.als_run_en), 0);
        check("rst_white", 32'(bus.pattern_white), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_rv", 32'(bus.result_valid), 0);
        check("rst_to", 32'(bus.timeout), 0);
        check("rst_base", 32'(bus.baseline), 0);
        check("rst_lag", bus.lag_cycles, 0);

        // shot 1: baseline 10, delta 20, lag 40
        do_start(8'd20);
        check("s1_busy", 32'(bus.busy), 1);
        check("s1_als", 32'(bus.als_run_en), 1);
        check("s1_state", 32'(dbg_state), 32'(ST_SETTLE));
        ack();
        check("ack_in_settle", 32'(dbg_state), 32'(ST_SETTLE));
        bus.start = 1'b1;
        cycle();
        check("start_busy_ign", 32'(dbg_state), 32'(ST_SETTLE));
        send_sample(8'd200);
        send_sample(8'd3);
        check("s1_base_state", 32'(dbg_state), 32'(ST_BASE));
        repeat (7) send_sample(8'd10);
        check("s1_white_lo", 32'(bus.pattern_white), 0);
        send_sample(8'd10);
        check("s1_baseline", 32'(bus.baseline), 10);
        check("s1_white_hi", 32'(bus.pattern_white), 1);
        check("s1_arm", 32'(dbg_state), 32'(ST_ARM));
        ack();
        check("s1_measure", 32'(dbg_state), 32'(ST_MEASURE));
        idle(4);
        send_sample(8'd29);
        check("s1_29_noqual", 32'(dbg_state), 32'(ST_MEASURE));
        idle(34);
        send_sample(8'd30);
        check("s1_rv", 32'(bus.result_valid), 1);
        check("s1_lag", bus.lag_cycles, 40);
        check("s1_to", 32'(bus.timeout), 0);
        check("s1_white_end", 32'(bus.pattern_white), 0);
        check("s1_busy_end", 32'(bus.busy), 0);
        check("s1_done", 32'(dbg_state), 32'(ST_DONE));

        // shot 2: start from DONE clears result, floor average, ARM timeout
        do_start(8'd20);
        check("s2_rv_clr", 32'(bus.result_valid), 0);
        check("s2_lag_clr", bus.lag_cycles, 0);
        send_sample(8'd200);
        send_sample(8'd3);
        send_sample(8'd10);
        repeat (7) send_sample(8'd11);
        check("s2_baseline", 32'(bus.baseline), 10);
        idle(TIMEOUT - 1);
        check("s2_arm_hold", 32'(dbg_state), 32'(ST_ARM));
        cycle();
        check("s2_to", 32'(bus.timeout), 1);
        check("s2_lag", bus.lag_cycles, TIMEOUT);
        check("s2_rv", 32'(bus.result_valid), 1);

        // shot 3: threshold above 255 never qualifies
        run_to_arm(8'd10, 8'd250, 8'd250);
        check("s3_baseline", 32'(bus.baseline), 250);
        ack();
        repeat (TIMEOUT - 1) send_sample(8'd255);
        check("s3_pre_to", 32'(bus.timeout), 0);
        check("s3_pre_state", 32'(dbg_state), 32'(ST_MEASURE));
        send_sample(8'd255);
        check("s3_to", 32'(bus.timeout), 1);
        check("s3_lag", bus.lag_cycles, TIMEOUT);

        // shot 4: qualifying sample on the watchdog's last edge
        run_to_arm(8'd20, 8'd10, 8'd10);
        bus.sample = 8'd255;
        bus.sample_valid = 1'b1;
        ack();
        check("s4_ack_sample_ign", 32'(dbg_state), 32'(ST_MEASURE));
        idle(TIMEOUT - 1);
        send_sample(8'd30);
        check("s4_to", 32'(bus.timeout), 0);
        check("s4_lag", bus.lag_cycles, TIMEOUT);
        check("s4_rv", 32'(bus.result_valid), 1);

        // shot 5: abort mid-MEASURE with a simultaneous start
        run_to_arm(8'd20, 8'd10, 8'd10);
        ack();
        idle(3);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        cycle();
        bus.abort = 1'b0;
        check("ab_state", 32'(dbg_state), 32'(ST_IDLE));
        check("ab_als", 32'(bus.als_run_en), 0);
        check("ab_white", 32'(bus.pattern_white), 0);
        check("ab_busy", 32'(bus.busy), 0);
        check("ab_rv", 32'(bus.result_valid), 0);
        check("ab_to", 32'(bus.timeout), 0);
        check("ab_base", 32'(bus.baseline), 0);
        check("ab_lag", bus.lag_cycles, 0);
        cycle();
        check("ab_stay_idle", 32'(dbg_state), 32'(ST_IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lag_meas_ctrl.md
# lag_meas_ctrl

Measurement sequencer for one input-lag shot. It enables the ambient-light-sensor reader and discards its warm-up samples, then averages a black-screen baseline. It requests a white pattern from the video generator and counts clock cycles from the generator's frame-start acknowledge to the first sensor sample exceeding baseline + delta. It sits between the ALS reader, the pattern generator and the result/UI logic.

## Interface
- SETTLE_SAMPLES, 16: ALS samples discarded after enabling the reader (1..255).
- TIMEOUT_CYCLES, 100_000_000: watchdog limit in ARM and MEASURE (≥2, < 2^CNT_W).
- CNT_W, 32: width of lag counter and watchdog.
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to run a shot; ignored while busy.
- abort  in  1  level; forces return to IDLE.
- delta  in  8  required rise above baseline; sampled on accepted start.
- sample  in  8  ALS reading.
- sample_valid  in  1  one-cycle strobe qualifying sample.
- pattern_ack  in  1  one-cycle strobe: first frame with requested pattern begins scan-out.
- als_run_en  out  1  enable to ALS reader.
- pattern_white  out  1  pattern request: 1 = white, 0 = black.
- busy  out  1  high in every state except IDLE/DONE.
- result_valid  out  1  level; result fields valid.
- timeout  out  1  result flag: shot ended by watchdog.
- baseline  out  8  averaged black level of last shot.
- lag_cycles  out  CNT_W  measured lag.

## Operation
- All outputs are registered. Reset values are 0 for all outputs; state is IDLE.
- States:
  - IDLE: outputs idle.
  - SETTLE: als_run_en=1, pattern_white=0; counts sample_valid strobes; goes to BASE on the SETTLE_SAMPLES-th strobe.
  - BASE: accumulates 8 samples into an 11-bit sum; on the 8th strobe, baseline <= sum[10:3] (floor), then goes to ARM.
  - ARM: pattern_white=1; waits for pattern_ack; on ack, watchdog and lag counter clear to 0, then goes to MEASURE.
  - MEASURE: counter increments every edge; qualifying sample is sample_valid && ({1'b0,sample} ≥ {1'b0,baseline}+delta), a 9-bit compare with no saturation.
  - DONE: als_run_en=0, pattern_white=0, result_valid=1, busy=0; start is accepted here as from IDLE.
- Transitions:
  - IDLE/DONE + start → SETTLE; result_valid, timeout and lag_cycles clear; delta is latched.
  - MEASURE + qualifying sample → DONE, lag_cycles <= cnt+1, timeout=0.
  - ARM or MEASURE with watchdog == TIMEOUT_CYCLES-1 and no qualifying sample on that edge → DONE, timeout=1, lag_cycles <= TIMEOUT_CYCLES.
- Qualifying sample and timeout on the same edge: the measurement wins (timeout=0).
- If baseline+delta > 255, no sample qualifies and the shot ends in timeout.
- pattern_ack outside ARM is ignored. A sample_valid on the edge that ack is taken in ARM is ignored.
- abort (any state) → IDLE on the next edge. all outputs return to reset values, including result_valid.
- abort has priority over start.
- resetn mid-shot behaves as abort.
- The watchdog runs only in ARM and MEASURE. It restarts at 0 on entry to each.

## Timing
- start sampled at edge E → busy=1, als_run_en=1 after E.
- Baseline is visible one edge after the 8th BASE strobe, the same edge pattern_white rises.
- Lag definition: pattern_ack sampled at edge E0, qualifying sample sampled at edge En → lag_cycles = n; result_valid rises after En.
- No latency is added between the qualifying edge and result_valid (same register update).
- Minimum shot length: SETTLE_SAMPLES+8 strobes, plus 1 ack, plus 1 edge.

## Test plan
- Bench parameters: SETTLE_SAMPLES=2, TIMEOUT_CYCLES=1000.
  - Start, delta=20. Feed 2 samples, then 8 samples of 10 → baseline=10. Ack, then a sample of 29 at +5 edges and a sample of 30 at +40 edges → lag_cycles=40, timeout=0, result_valid=1, pattern_white=0.
  - Baseline samples 10,11,11,11,11,11,11,11 (sum 87) → baseline=10.
  - baseline=250, delta=10. Feed samples of 255 in MEASURE → timeout=1 exactly 1000 edges after the ack, lag_cycles=1000.
  - No pattern_ack for 1000 edges in ARM → timeout=1. An ack injected during SETTLE is ignored.
  - Qualifying sample coinciding with watchdog=999 → timeout=0, lag_cycles=1000.
  - abort mid-MEASURE → next edge all outputs 0, state IDLE. A start on the same edge as abort is ignored. A start during busy has no effect; a start from DONE clears result_valid.
